huffman_encoder: RTL

Compresses a stream of 4-bit weight symbols into 32-bit packed words using the team's fixed Huffman codebook, for writing to D_xmem / SRAM. It is the transmit-side counterpart of huffman_decoder; its output words must decode bit-exactly through that block. It sits between the weight-quantisation stage and the SRAM write port.

---
 rtl/huffman_encoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/huffman_encoder.sv
// Fixed-codebook Huffman encoder: packs 4-bit weight symbols MSB-first into 32-bit words.
// Optional HUFF_ENC_STATS_EN adds stat_syms/stat_bits counters.
module huffman_encoder #(
  parameter int unsigned ACC_W    = 64,
  parameter int unsigned MAX_CODE = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic [5:0]  word_bits,
  output logic        flush_done,
`ifdef HUFF_ENC_STATS_EN
  output logic [31:0] stat_syms,
  output logic [31:0] stat_bits,
`endif
  output logic        sym_err
);

  localparam logic [6:0] ReadyMax = 7'(ACC_W - MAX_CODE);

  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [6:0]        count_q, count_d;
  logic [31:0]       word_out_q, word_out_d;
  logic              word_valid_q, word_valid_d;
  logic              word_last_q, word_last_d;
  logic [5:0]        word_bits_q, word_bits_d;
  logic              sym_err_q, sym_err_d;

  logic              out_free;
  logic              accept;
  logic [2:0]        code_len;
  logic [5:0]        code_bits;

  // Returns {length, code left-aligned in 6 bits}; length 0 marks the unmapped symbol.
  function automatic logic [8:0] lookup(input logic [3:0] s);
    logic [8:0] r;
    case (s)
      4'h0:    r = {3'd2, 6'b000000};
      4'h1:    r = {3'd3, 6'b110000};
      4'hE:    r = {3'd3, 6'b010000};
      4'hF:    r = {3'd3, 6'b101000};
      4'h2:    r = {3'd4, 6'b111000};
      4'h7:    r = {3'd4, 6'b100000};
      4'hD:    r = {3'd4, 6'b011100};
      4'h3:    r = {3'd5, 6'b100100};
      4'h4:    r = {3'd5, 6'b011000};
      4'h9:    r = {3'd5, 6'b111110};
      4'hC:    r = {3'd5, 6'b100110};
      4'h5:    r = {3'd6, 6'b111100};
      4'h6:    r = {3'd6, 6'b011010};
      4'hA:    r = {3'd6, 6'b011011};
      4'hB:    r = {3'd6, 6'b111101};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  assign {code_len, code_bits} = lookup(sym_in);

  assign sym_ready = (state_q == StRun) && (count_q <= ReadyMax);
  assign accept    = sym_valid && sym_ready && !flush;
  assign out_free  = !word_valid_q || word_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    word_out_d   = word_out_q;
    word_bits_d  = word_bits_q;
    word_last_d  = word_last_q;
    word_valid_d = word_valid_q && !word_ready;
    sym_err_d    = 1'b0;

    // Full-word drain runs in every state and precedes any append.
    if (count_q >= 7'd32 && out_free) begin
      word_out_d   = acc_q[ACC_W-1 -: 32];
      word_bits_d  = 6'd32;
      word_last_d  = 1'b0;
      word_valid_d = 1'b1;
      acc_d        = {acc_q[ACC_W-33:0], 32'd0};
      count_d      = count_q - 7'd32;
    end

    unique case (state_q)
      StRun: begin
        if (flush && sym_ready) begin
          state_d = StFlush;
        end else if (accept) begin
          if (code_len == 3'd0) begin
            sym_err_d = 1'b1;
          end else begin
            acc_d   = acc_d | ({code_bits, 58'd0} >> count_d);
            count_d = count_d + 7'(code_len);
          end
        end
      end
      StFlush: begin
        if (count_q == 7'd0) begin
          state_d = StDone;
        end else if (count_q < 7'd32 && out_free) begin
          word_out_d   = acc_q[ACC_W-1 -: 32];
          word_bits_d  = count_q[5:0];
          word_last_d  = 1'b1;
          word_valid_d = 1'b1;
          acc_d        = '0;
          count_d      = 7'd0;
          state_d      = StDone;
        end
      end
      StDone: begin
        acc_d   = '0;
        count_d = 7'd0;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StRun;
      acc_q        <= '0;
      count_q      <= 7'd0;
      word_out_q   <= 32'd0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      word_bits_q  <= 6'd0;
      sym_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      word_bits_q  <= word_bits_d;
      sym_err_q    <= sym_err_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_last  = word_last_q;
  assign word_bits  = word_bits_q;
  assign sym_err    = sym_err_q;
  assign flush_done = (state_q == StDone);

`ifdef HUFF_ENC_STATS_EN
  logic [31:0] stat_syms_q, stat_bits_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_syms_q <= 32'd0;
      stat_bits_q <= 32'd0;
    end else if (accept && code_len != 3'd0) begin
      stat_syms_q <= stat_syms_q + 32'd1;
      stat_bits_q <= stat_bits_q + 32'(code_len);
    end
  end

  assign stat_syms = stat_syms_q;
  assign stat_bits = stat_bits_q;
`endif

endmodule
